// File: rtl/muldiv_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MFLO  = 6'h12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_DIVU  = 2'd1,
    OP_MULT  = 2'd2,
    OP_DIV   = 2'd3
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_res_t;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative engine: shift-add multiply / restoring divide, one step per cycle.
// Signed conditioning is compiled in only when MULDIV_SIGNED_EN is defined.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  op_e             op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output md_res_t         res_o
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned AW = 2 * XLEN;

  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [XLEN-1:0] opd_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q;
  logic            neg_q;
  logic            rem_neg_q;
  logic            div0_q;

  logic            sgn_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic [XLEN-1:0] a_mag_c;
  logic [XLEN-1:0] b_mag_c;

`ifdef MULDIV_SIGNED_EN
  assign sgn_c = op_is_signed(op_i);
`else
  assign sgn_c = 1'b0;
`endif

  // Operands enter the engine as magnitudes; signs are remembered for the final fixup.
  assign a_neg_c = sgn_c & a_i[XLEN-1];
  assign b_neg_c = sgn_c & b_i[XLEN-1];
  assign a_mag_c = a_neg_c ? (~a_i + XLEN'(1)) : a_i;
  assign b_mag_c = b_neg_c ? (~b_i + XLEN'(1)) : b_i;

  logic [XLEN:0]   sum_c;
  logic [XLEN:0]   shl_c;
  logic [XLEN+1:0] diff_c;
  logic            fits_c;

  // One iteration: upper half is the partial product sum or the partial remainder.
  always_comb begin
    sum_c  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    shl_c  = acc_q[AW-1:XLEN-1];
    diff_c = {1'b0, shl_c} - {2'b00, opd_q};
    fits_c = ~diff_c[XLEN+1];
    if (is_div_q) begin
      acc_d = {(fits_c ? diff_c[XLEN-1:0] : shl_c[XLEN-1:0]), acc_q[XLEN-2:0], fits_c};
    end else begin
      acc_d = {sum_c, acc_q[XLEN-1:1]};
    end
  end

  logic [AW-1:0]   prod_c;
  logic [XLEN-1:0] quo_c;
  logic [XLEN-1:0] rem_c;

  // Result of the final step with signs reapplied; only consumed on the last iteration.
  always_comb begin
    prod_c = neg_q ? (~acc_d + AW'(1)) : acc_d;
    quo_c  = neg_q ? (~acc_d[XLEN-1:0] + XLEN'(1)) : acc_d[XLEN-1:0];
    rem_c  = rem_neg_q ? (~acc_d[AW-1:XLEN] + XLEN'(1)) : acc_d[AW-1:XLEN];
    if (is_div_q) begin
      res_o.hi = rem_c;
      res_o.lo = div0_q ? {XLEN{1'b1}} : quo_c;
    end else begin
      res_o.hi = prod_c[AW-1:XLEN];
      res_o.lo = prod_c[XLEN-1:0];
    end
  end

  assign done_o = step_i && (cnt_q == CW'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opd_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (start_i) begin
      cnt_q     <= '0;
      is_div_q  <= op_is_div(op_i);
      neg_q     <= a_neg_c ^ b_neg_c;
      rem_neg_q <= a_neg_c;
      div0_q    <= (b_i == '0);
      if (op_is_div(op_i)) begin
        acc_q <= {XLEN'(0), a_mag_c};
        opd_q <= b_mag_c;
      end else begin
        acc_q <= {XLEN'(0), b_mag_c};
        opd_q <= a_mag_c;
      end
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: decode, IDLE/BUSY/DONE control, HI/LO and MFHI/MFLO mux.
// Define MULDIV_SIGNED_EN to also execute MULT/DIV.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             RType_EX,
  input  logic [5:0]       Funct_EX,
  input  logic [XLEN-1:0]  RD1_EX,
  input  logic [XLEN-1:0]  RD2_EX,
  output logic             Stall_MD,
  output logic             MD_Sel,
  output logic [XLEN-1:0]  MD_Result,
  output logic             Busy,
  output logic [XLEN-1:0]  Hi,
  output logic [XLEN-1:0]  Lo
);

  state_e          state_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  logic    start_c;
  logic    rd_hi_c;
  logic    rd_lo_c;
  op_e     op_c;
  logic    core_start;
  logic    core_done;
  md_res_t core_res;

  always_comb begin
    start_c = 1'b0;
    rd_hi_c = 1'b0;
    rd_lo_c = 1'b0;
    op_c    = OP_MULTU;
    if (RType_EX) begin
      case (Funct_EX)
        MULTU: begin start_c = 1'b1; op_c = OP_MULTU; end
        DIVU:  begin start_c = 1'b1; op_c = OP_DIVU;  end
`ifdef MULDIV_SIGNED_EN
        MULT:  begin start_c = 1'b1; op_c = OP_MULT;  end
        DIV:   begin start_c = 1'b1; op_c = OP_DIV;   end
`endif
        MFHI:  rd_hi_c = 1'b1;
        MFLO:  rd_lo_c = 1'b1;
        default: ;
      endcase
    end
  end

  // A start op is only accepted from IDLE; in DONE the same op is still in EX and is ignored.
  assign core_start = Rst_n && (state_q == IDLE) && start_c;
  assign Stall_MD   = core_start || (state_q == BUSY);
  assign Busy       = (state_q == BUSY);
  assign MD_Sel     = rd_hi_c || rd_lo_c;
  assign MD_Result  = rd_hi_c ? hi_q : (rd_lo_c ? lo_q : '0);
  assign Hi         = hi_q;
  assign Lo         = lo_q;

  muldiv_core #(.ITER(ITER)) u_core (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start_i (core_start),
    .step_i  (state_q == BUSY),
    .op_i    (op_c),
    .a_i     (RD1_EX),
    .b_i     (RD2_EX),
    .done_o  (core_done),
    .res_o   (core_res)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (core_start) state_q <= BUSY;
        BUSY: begin
          if (core_done) begin
            hi_q    <= core_res.hi;
            lo_q    <= core_res.lo;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed, table-driven bench for ex_muldiv_unit; hand sequences cover reset and back-to-back ops.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int ITER = 32;
  localparam int NV   = 13;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        RType_EX;
  logic [5:0]  Funct_EX;
  logic [31:0] RD1_EX;
  logic [31:0] RD2_EX;
  logic        Stall_MD;
  logic        MD_Sel;
  logic [31:0] MD_Result;
  logic        Busy;
  logic [31:0] Hi;
  logic [31:0] Lo;

  ex_muldiv_unit #(.ITER(ITER)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .RType_EX  (RType_EX),
    .Funct_EX  (Funct_EX),
    .RD1_EX    (RD1_EX),
    .RD2_EX    (RD2_EX),
    .Stall_MD  (Stall_MD),
    .MD_Sel    (MD_Sel),
    .MD_Result (MD_Result),
    .Busy      (Busy),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          nop;
  } vec_t;

  vec_t        vecs[NV];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mhi   = '0;
  logic [31:0] mlo   = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Counts consecutive stalled cycles starting with the current one; bounded.
  task automatic count_stall(output int n);
    n = 0;
    while (Stall_MD === 1'b1 && n < 200) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic drive(input logic rt, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge Clk);
    #1;
    RType_EX = rt;
    Funct_EX = f;
    RD1_EX   = a;
    RD2_EX   = b;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    int          es;
    logic [31:0] eh;
    logic [31:0] el;
    if (v.nop) begin
      eh = mhi; el = mlo; es = 0;
    end else begin
      eh = v.hi; el = v.lo; es = ITER + 1;
    end
    drive(1'b1, v.f, v.a, v.b);
    @(negedge Clk);
    count_stall(n);
    chk($sformatf("v%0d_stall_cycles", idx), 64'(n), 64'(es));
    chk($sformatf("v%0d_busy_done", idx), 64'(Busy), 64'd0);
    chk($sformatf("v%0d_hi", idx), 64'(Hi), 64'(eh));
    chk($sformatf("v%0d_lo", idx), 64'(Lo), 64'(el));
    mhi = eh;
    mlo = el;
    drive(1'b1, MFLO, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge Clk);
    chk($sformatf("v%0d_mflo_sel", idx), 64'(MD_Sel), 64'd1);
    chk($sformatf("v%0d_mflo", idx), 64'(MD_Result), 64'(el));
    chk($sformatf("v%0d_mflo_nostall", idx), 64'(Stall_MD), 64'd0);
    drive(1'b1, MFHI, 32'h0, 32'h0);
    @(negedge Clk);
    chk($sformatf("v%0d_mfhi", idx), 64'(MD_Result), 64'(eh));
    drive(1'b0, 6'h00, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{f:MULTU, a:32'hFFFF_FFFF, b:32'h2,         hi:32'h1,         lo:32'hFFFF_FFFE, nop:1'b0};
    vecs[1] = '{f:DIVU,  a:32'd100,       b:32'd7,         hi:32'd2,         lo:32'd14,        nop:1'b0};
    vecs[2] = '{f:DIVU,  a:32'd5,         b:32'd0,         hi:32'd5,         lo:32'hFFFF_FFFF, nop:1'b0};
    vecs[3] = '{f:MULTU, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, hi:32'hFFFF_FFFE, lo:32'h1,         nop:1'b0};
    vecs[4] = '{f:DIVU,  a:32'hFFFF_FFFF, b:32'd1,         hi:32'd0,         lo:32'hFFFF_FFFF, nop:1'b0};
    vecs[5] = '{f:MULTU, a:32'h1234_5678, b:32'd0,         hi:32'd0,         lo:32'd0,         nop:1'b0};
    vecs[6] = '{f:DIVU,  a:32'd7,         b:32'd100,       hi:32'd7,         lo:32'd0,         nop:1'b0};
    vecs[7] = '{f:MULTU, a:32'h0001_0000, b:32'h0001_0000, hi:32'h1,         lo:32'h0,         nop:1'b0};
`ifdef MULDIV_SIGNED_EN
    vecs[8]  = '{f:DIV,  a:32'hFFFF_FFF9, b:32'd2,         hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFD, nop:1'b0};
    vecs[9]  = '{f:MULT, a:32'hFFFF_FFFD, b:32'd5,         hi:32'hFFFF_FFFF, lo:32'hFFFF_FFF1, nop:1'b0};
    vecs[10] = '{f:DIV,  a:32'h8000_0000, b:32'hFFFF_FFFF, hi:32'h0,         lo:32'h8000_0000, nop:1'b0};
    vecs[11] = '{f:DIV,  a:32'hFFFF_FFFB, b:32'd0,         hi:32'hFFFF_FFFB, lo:32'hFFFF_FFFF, nop:1'b0};
    vecs[12] = '{f:DIV,  a:32'd7,         b:32'hFFFF_FFFE, hi:32'd1,         lo:32'hFFFF_FFFD, nop:1'b0};
`else
    vecs[8]  = '{f:DIV,  a:32'hFFFF_FFF9, b:32'd2,         hi:32'h0, lo:32'h0, nop:1'b1};
    vecs[9]  = '{f:MULT, a:32'hFFFF_FFFD, b:32'd5,         hi:32'h0, lo:32'h0, nop:1'b1};
    vecs[10] = '{f:DIV,  a:32'h8000_0000, b:32'hFFFF_FFFF, hi:32'h0, lo:32'h0, nop:1'b1};
    vecs[11] = '{f:DIV,  a:32'hFFFF_FFFB, b:32'd0,         hi:32'h0, lo:32'h0, nop:1'b1};
    vecs[12] = '{f:MULTU, a:32'd9,        b:32'd9,         hi:32'h0, lo:32'd81, nop:1'b0};
`endif

    // Reset with a start op already presented: nothing may stall.
    Rst_n    = 1'b0;
    RType_EX = 1'b1;
    Funct_EX = MULTU;
    RD1_EX   = 32'd3;
    RD2_EX   = 32'd3;
    #1;
    chk("rst_stall", 64'(Stall_MD), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    repeat (3) @(negedge Clk);
    chk("rst_busy_held", 64'(Busy), 64'd0);
    RType_EX = 1'b0;
    Rst_n    = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Non-MD R-type funct and a non-R-type MFLO encoding are both inert.
    drive(1'b1, 6'h21, 32'h5, 32'h6);
    @(negedge Clk);
    chk("add_stall", 64'(Stall_MD), 64'd0);
    chk("add_sel", 64'(MD_Sel), 64'd0);
    chk("add_result", 64'(MD_Result), 64'd0);
    @(negedge Clk);
    chk("add_hi_kept", 64'(Hi), 64'(mhi));
    drive(1'b0, MFLO, 32'h0, 32'h0);
    @(negedge Clk);
    chk("nonr_mflo_sel", 64'(MD_Sel), 64'd0);
    chk("nonr_mflo_result", 64'(MD_Result), 64'd0);

    // Reset pulsed at BUSY count 10, then the same op restarts on the first edge after release.
    drive(1'b1, MULTU, 32'd7, 32'd6);
    @(negedge Clk);
    repeat (11) @(negedge Clk);
    chk("mid_busy", 64'(Busy), 64'd1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(Stall_MD), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_hi", 64'(Hi), 64'd0);
    chk("mid_rst_lo", 64'(Lo), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    count_stall(n);
    chk("restart_stall_cycles", 64'(n), 64'(ITER + 1));
    chk("restart_hi", 64'(Hi), 64'd0);
    chk("restart_lo", 64'(Lo), 64'd42);

    // Back-to-back MULTU then DIVU separated only by the DONE cycle.
    drive(1'b1, MULTU, 32'd3, 32'd4);
    @(negedge Clk);
    count_stall(n);
    chk("b2b_mul_stall_cycles", 64'(n), 64'(ITER + 1));
    chk("b2b_mul_lo", 64'(Lo), 64'd12);
    chk("b2b_mul_hi", 64'(Hi), 64'd0);
    drive(1'b1, DIVU, 32'd50, 32'd8);
    @(negedge Clk);
    count_stall(n);
    chk("b2b_div_stall_cycles", 64'(n), 64'(ITER + 1));
    chk("b2b_div_lo", 64'(Lo), 64'd6);
    chk("b2b_div_hi", 64'(Hi), 64'd2);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    @(negedge Clk);
    chk("b2b_idle_stall", 64'(Stall_MD), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
